life_step_engine: RTL and testbench

//  Sequential next-generation engine for the Game of Life board. Snapshots an XxY board on start,

---
 rtl/life_step_engine.sv | 176 +++++++++++++++++
 tb/tb_life_step_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_engine.sv
// life_step_engine: sequential Game of Life next-generation engine.
// On an accepted start, the board, the wrap mode and the rule are snapshotted.
// The engine then scans the snapshot one cell per clock, with x advancing fastest.
// The whole next board is published in one update, and done is asserted for one cycle.
// Optional feature macro: LIFE_RULE_EN adds the birth_mask/survive_mask inputs
// for a programmable rule. Without it, the fixed Conway B3/S23 rule is used.
module life_step_engine #(
    parameter int X     = 8,
    parameter int Y     = 8,
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int GENW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   wrap,
    input  logic [X*Y-1:0]         board_in,
`ifdef LIFE_RULE_EN
    input  logic [8:0]             birth_mask,
    input  logic [8:0]             survive_mask,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [X*Y-1:0]         board_out,
    output logic [LOG2X+LOG2Y:0]   population,
    output logic                   stable,
    output logic [GENW-1:0]        gen_cnt
);
    localparam int N  = X * Y;
    localparam int IW = $clog2(N);
    localparam int PW = LOG2X + LOG2Y + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_n;
    logic [N-1:0]       snap;       // board being evolved, frozen for the whole scan
    logic [N-1:0]       shadow;     // next-state bits collected so far
    logic [N-1:0]       nxt_board;  // shadow with the current cell merged in
    logic               wrap_s;
    logic [LOG2X-1:0]   cx;
    logic [LOG2Y-1:0]   cy;
    logic [IW-1:0]      idx;        // linear cell index y*X + x, tracks cx/cy
    logic [PW-1:0]      acc;
    logic [8:0]         rule_b, rule_s;
    logic               accept, last, alive, nbit;
    logic [3:0]         cnt;
    int                 nx, ny;
    logic               on_board;
    logic [IW-1:0]      ni;

    assign accept = start && (state != SCAN);
    assign last   = (state == SCAN) && (cx == LOG2X'(X-1)) && (cy == LOG2Y'(Y-1));

`ifdef LIFE_RULE_EN
    logic [8:0] birth_s, survive_s;

    // capture the programmable rule together with the board snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            birth_s   <= '0;
            survive_s <= '0;
        end else if (accept) begin
            birth_s   <= birth_mask;
            survive_s <= survive_mask;
        end
    end

    assign rule_b = birth_s;
    assign rule_s = survive_s;
`else
    assign rule_b = 9'h008;
    assign rule_s = 9'h00C;
`endif

    // next-state logic: start wins over returning to IDLE so steps can chain
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SCAN;
            SCAN:    if (last)  state_n = DONE;
            DONE:    state_n = start ? SCAN : IDLE;
            default: state_n = IDLE;
        endcase
        busy = (state == SCAN);
        done = (state == DONE);
    end

    // 8-neighbour count of the cell under the scan counter; off-board reads dead unless wrapping
    always_comb begin
        cnt      = '0;
        nx       = 0;
        ny       = 0;
        on_board = 1'b0;
        ni       = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    nx       = int'(cx) + dx;
                    ny       = int'(cy) + dy;
                    on_board = 1'b1;
                    if (nx < 0) begin
                        nx = X - 1;
                        on_board = wrap_s;
                    end else if (nx >= X) begin
                        nx = 0;
                        on_board = wrap_s;
                    end
                    if (ny < 0) begin
                        ny = Y - 1;
                        on_board = on_board && wrap_s;
                    end else if (ny >= Y) begin
                        ny = 0;
                        on_board = on_board && wrap_s;
                    end
                    ni = IW'(ny * X + nx);
                    if (on_board && snap[ni]) cnt = cnt + 4'd1;
                end
            end
        end
    end

    // apply the rule and merge the result into the shadow board
    always_comb begin
        alive          = snap[idx];
        nbit           = alive ? rule_s[cnt] : rule_b[cnt];
        nxt_board      = shadow;
        nxt_board[idx] = nbit;
    end

    // state, snapshot, scan counters and the published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            shadow     <= '0;
            wrap_s     <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            idx        <= '0;
            acc        <= '0;
            board_out  <= '0;
            population <= '0;
            stable     <= 1'b0;
            gen_cnt    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                snap   <= board_in;
                wrap_s <= wrap;
                cx     <= '0;
                cy     <= '0;
                idx    <= '0;
                acc    <= '0;
            end else if (state == SCAN) begin
                shadow <= nxt_board;
                acc    <= acc + PW'(nbit);
                idx    <= idx + IW'(1);
                if (cx == LOG2X'(X-1)) begin
                    cx <= '0;
                    cy <= cy + LOG2Y'(1);
                end else begin
                    cx <= cx + LOG2X'(1);
                end
                // last cell: publish board, count and still-life flag in one update
                if (last) begin
                    board_out  <= nxt_board;
                    population <= acc + PW'(nbit);
                    stable     <= (nxt_board == snap);
                    gen_cnt    <= gen_cnt + GENW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_life_step_engine.sv
// Scoreboard bench for life_step_engine (8x8 board).
// Expected generations are pushed when a step is launched.
// They are popped and compared on every done.
module tb_life_step_engine;
    logic        clk = 1'b0;
    logic        rst, start, wrap, fb;
    logic [63:0] stim, board_in, board_out;
    logic        busy, done, stable;
    logic [6:0]  population;
    logic [15:0] gen_cnt;
    logic [8:0]  bm_v = 9'h008;
    logic [8:0]  sm_v = 9'h00C;

    typedef struct {
        logic [63:0] board;
        logic [6:0]  pop;
        logic        stable;
        logic [15:0] gen;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0;
    int          nerr = 0;
    int          ndone = 0;
    logic [15:0] exp_gen = '0;

    assign board_in = fb ? board_out : stim;

    always #5 clk = ~clk;

    life_step_engine dut (
        .clk(clk), .rst(rst), .start(start), .wrap(wrap), .board_in(board_in),
`ifdef LIFE_RULE_EN
        .birth_mask(bm_v), .survive_mask(sm_v),
`endif
        .busy(busy), .done(done), .board_out(board_out), .population(population),
        .stable(stable), .gen_cnt(gen_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: modulo arithmetic for wrap, bounds test otherwise
    function automatic logic [63:0] life_next(input logic [63:0] b, input logic w,
                                              input logic [8:0] bm, input logic [8:0] sm);
        logic [63:0] r;
        int n, xx, yy;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (!(dx == 0 && dy == 0)) begin
                            xx = x + dx;
                            yy = y + dy;
                            if (w) begin
                                xx = (xx + 8) % 8;
                                yy = (yy + 8) % 8;
                                if (b[6'(yy*8+xx)]) n++;
                            end else if (xx >= 0 && xx < 8 && yy >= 0 && yy < 8) begin
                                if (b[6'(yy*8+xx)]) n++;
                            end
                        end
                    end
                end
                r[6'(y*8+x)] = b[6'(y*8+x)] ? sm[4'(n)] : bm[4'(n)];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] cells(input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r = '0;
        if (a >= 0) r[6'(a)] = 1'b1;
        if (b >= 0) r[6'(b)] = 1'b1;
        if (c >= 0) r[6'(c)] = 1'b1;
        if (d >= 0) r[6'(d)] = 1'b1;
        return r;
    endfunction

    task automatic push_exp(input logic [63:0] nb, input logic [63:0] src);
        exp_t e;
        exp_gen  = exp_gen + 16'd1;
        e.board  = nb;
        e.pop    = 7'($countones(nb));
        e.stable = (nb == src);
        e.gen    = exp_gen;
        sbq.push_back(e);
    endtask

    // scoreboard consumer: every done must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            ndone++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_board", board_out, e.board);
                chk("sb_pop", 64'(population), 64'(e.pop));
                chk("sb_stable", 64'(stable), 64'(e.stable));
                chk("sb_gen", 64'(gen_cnt), 64'(e.gen));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        exp_gen = '0;
    endtask

    // one step: launch, optionally poke start mid-scan, measure cycles to done
    task automatic do_step(input logic [63:0] b, input logic w, input logic mid);
        int lat;
        push_exp(life_next(b, w, bm_v, sm_v), b);
        @(negedge clk);
        stim  = b;
        wrap  = w;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("busy_in_scan", 64'(busy), 64'd1);
            if (mid && lat == 10) start = 1'b1;
            if (mid && lat == 11) start = 1'b0;
            if (done) break;
        end
        chk("done_latency", 64'(lat), 64'd65);
    endtask

    logic [63:0] hb, vb, blk, vbl, gl, g;
    int d0, cyc;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wrap = 1'b0; fb = 1'b0; stim = '0;
        do_reset();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_board", board_out, 64'd0);
        chk("rst_pop", 64'(population), 64'd0);
        chk("rst_stable", 64'(stable), 64'd0);
        chk("rst_gen", 64'(gen_cnt), 64'd0);

        // horizontal blinker, clamped edges, two steps
        hb = cells(26, 27, 28, -1);
        vb = cells(19, 27, 35, -1);
        do_step(hb, 1'b0, 1'b0);
        chk("blink1_board", board_out, vb);
        chk("blink1_pop", 64'(population), 64'd3);
        chk("blink1_stable", 64'(stable), 64'd0);
        chk("blink1_gen", 64'(gen_cnt), 64'd1);
        repeat (5) @(negedge clk);
        chk("hold_board", board_out, vb);
        chk("hold_busy", 64'(busy), 64'd0);
        do_step(vb, 1'b0, 1'b0);
        chk("blink2_board", board_out, hb);
        chk("blink2_gen", 64'(gen_cnt), 64'd2);

        // still-life block in the corner, toroidal
        blk = cells(0, 1, 8, 9);
        do_step(blk, 1'b1, 1'b0);
        chk("block_board", board_out, blk);
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_pop", 64'(population), 64'd4);

        // vertical blinker on the right edge, clamped then toroidal
        vbl = cells(23, 31, 39, -1);
        do_step(vbl, 1'b0, 1'b0);
        chk("edge_clamp_board", board_out, cells(30, 31, -1, -1));
        chk("edge_clamp_pop", 64'(population), 64'd2);
        do_step(vbl, 1'b1, 1'b0);
        chk("edge_wrap_board", board_out, cells(30, 31, 24, -1));
        chk("edge_wrap_pop", 64'(population), 64'd3);

        // glider, 32 chained steps with start held and board fed back
        do_reset();
        gl = cells(1, 10, 16, 17) | cells(18, -1, -1, -1);
        g = gl;
        for (int k = 0; k < 32; k++) begin
            push_exp(life_next(g, 1'b1, bm_v, sm_v), g);
            g = life_next(g, 1'b1, bm_v, sm_v);
        end
        @(negedge clk);
        stim = gl; wrap = 1'b1; fb = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 fb = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 200);
            chk("glider_done", 64'(done), 64'd1);
            @(negedge clk);
            if (k < 32) chk("glider_no_idle", 64'(busy), 64'd1);
            else        chk("glider_end_idle", 64'(busy), 64'd0);
            if (k == 31) start = 1'b0;
        end
        fb = 1'b0;
        chk("glider_home", board_out, gl);
        chk("glider_gen", 64'(gen_cnt), 64'd32);

        // start poked mid-scan is ignored: exactly one done
        d0 = ndone;
        do_step(blk, 1'b0, 1'b1);
        repeat (80) @(negedge clk);
        chk("mid_start_dones", 64'(ndone - d0), 64'd1);
        chk("mid_start_idle", 64'(busy), 64'd0);

        // reset in the middle of a scan aborts with no done
        @(negedge clk);
        stim = hb; wrap = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        d0 = ndone;
        sbq.delete();
        exp_gen = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_board", board_out, 64'd0);
        chk("abort_pop", 64'(population), 64'd0);
        chk("abort_stable", 64'(stable), 64'd0);
        chk("abort_gen", 64'(gen_cnt), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (100) @(negedge clk);
        chk("abort_no_done", 64'(ndone - d0), 64'd0);

`ifdef LIFE_RULE_EN
        // B1/S-: a lone cell gives birth to its eight neighbours and dies
        bm_v = 9'h002;
        sm_v = 9'h000;
        do_step(cells(27, -1, -1, -1), 1'b0, 1'b0);
        chk("rule_board", board_out, cells(18, 19, 20, 26) | cells(28, 34, 35, 36));
        chk("rule_pop", 64'(population), 64'd8);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
